// File: rtl/mask_expand_if.sv
// Bundle-load handshake between the compressed-word producer and mask_expand.
// The producer drives i_im/i_valid; the expander answers with o_accept.
interface mask_expand_if #(
  parameter int W = 20
);
  logic [16*W-1:0] i_im;
  logic            i_valid;
  logic            o_accept;

  modport master (output i_im, output i_valid, input o_accept);
  modport slave  (input i_im, input i_valid, output o_accept);
endinterface

// File: rtl/mask_expand.sv
// Sparse-to-dense expander: loads ceil(N/16) compressed bundles, scatters them
// into a dense vector under the latched mask, then presents it 16 words per beat.
module mask_expand #(
  parameter int IL       = 8,
  parameter int FL       = 12,
  parameter int length   = 32,
  parameter int p_length = $clog2(length)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [length-1:0]                          i_mask,
  input  logic                                       input_ready,
  mask_expand_if.slave                               bus,
  input  logic                                       output_taken,
  output logic [16*(IL+FL)-1:0]                      o_im,
  output logic [length-1:0]                          o_mask,
  output logic [((p_length > 4) ? p_length-4 : 1)-1:0] o_beat,
  output logic [1:0]                                 state
);

  localparam int W     = IL + FL;
  localparam int NBEAT = length / 16;
  localparam int BW    = (p_length > 4) ? p_length - 4 : 1;
  localparam int CW    = p_length + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    EXPAND = 2'b11,
    OUTPUT = 2'b10
  } state_t;

  state_t                r_state;
  logic [length-1:0]     r_mask;
  logic [CW-1:0]         r_n;
  logic [CW-1:0]         r_nb;
  logic [CW-1:0]         r_bcnt;
  logic [p_length-1:0]   r_k;
  logic [CW-1:0]         r_ptr;
  logic                  r_accept;
  logic [BW-1:0]         r_beat;
  logic [W-1:0]          r_buf   [length];
  logic [W-1:0]          r_dense [length];

  logic [CW-1:0]         w_pop;
  logic [CW-1:0]         w_nb;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < length; i++)
      w_pop = w_pop + CW'(i_mask[i]);
    w_nb = CW'((32'(w_pop) + 32'd15) >> 4);
  end

  // LOAD holds one extra cycle with o_accept low after the last bundle, so an
  // empty mask and a full load leave LOAD the same way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_n      <= '0;
      r_nb     <= '0;
      r_bcnt   <= '0;
      r_k      <= '0;
      r_ptr    <= '0;
      r_accept <= 1'b0;
      r_beat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (input_ready) begin
            r_mask   <= i_mask;
            r_n      <= w_pop;
            r_nb     <= w_nb;
            r_bcnt   <= '0;
            r_k      <= '0;
            r_ptr    <= '0;
            r_beat   <= '0;
            r_accept <= (w_nb != '0);
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          if (r_accept) begin
            if (bus.i_valid) begin
              r_bcnt <= r_bcnt + CW'(1);
              if (r_bcnt + CW'(1) == r_nb)
                r_accept <= 1'b0;
            end
          end else begin
            r_state <= EXPAND;
          end
        end
        EXPAND: begin
          if (r_mask[r_k])
            r_ptr <= r_ptr + CW'(1);
          if (r_k == p_length'(length - 1))
            r_state <= OUTPUT;
          else
            r_k <= r_k + p_length'(1);
        end
        OUTPUT: begin
          if (output_taken) begin
            if (r_beat == BW'(NBEAT - 1)) begin
              r_beat  <= '0;
              r_state <= IDLE;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Slots past N in the final bundle are dropped rather than stored.
  always_ff @(posedge clk) begin
    if (r_state == LOAD && r_accept && bus.i_valid) begin
      for (int unsigned j = 0; j < 16; j++) begin
        if (32'(r_bcnt) * 32'd16 + j < 32'(r_n))
          r_buf[p_length'(32'(r_bcnt) * 32'd16 + j)] <= bus.i_im[j*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == EXPAND)
      r_dense[r_k] <= r_mask[r_k] ? r_buf[r_ptr[p_length-1:0]] : '0;
  end

  // Buffers are never reset, so the presented beat is gated on OUTPUT.
  always_comb begin
    o_im = '0;
    if (r_state == OUTPUT) begin
      for (int unsigned j = 0; j < 16; j++)
        o_im[j*W +: W] = r_dense[p_length'(32'd16 * 32'(r_beat) + j)];
    end
  end

  assign bus.o_accept = r_accept;
  assign o_mask       = r_mask;
  assign o_beat       = r_beat;
  assign state        = r_state;

endmodule

// File: tb/tb_mask_expand.sv
// Directed and randomized checks of mask_expand against a queue-based
// scatter model of the expected dense vector.
module tb_mask_expand;
  localparam int W  = 20;
  localparam int L  = 32;
  localparam int NB = L / 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             input_ready = 1'b0;
  logic             output_taken = 1'b0;
  logic [L-1:0]     i_mask = '0;
  logic [16*W-1:0]  o_im;
  logic [L-1:0]     o_mask;
  logic [0:0]       o_beat;
  logic [1:0]       state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] g_words[$];
  logic [L-1:0] m;

  mask_expand_if #(.W(W)) bus();

  mask_expand #(.IL(8), .FL(12), .length(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mask       (i_mask),
    .input_ready  (input_ready),
    .bus          (bus),
    .output_taken (output_taken),
    .o_im         (o_im),
    .o_mask       (o_mask),
    .o_beat       (o_beat),
    .state        (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [16*W-1:0] obs, input logic [16*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [L-1:0] mask);
    g_words.delete();
    for (int i = 0; i < $countones(mask); i++)
      g_words.push_back(W'($urandom));
  endtask

  task automatic run_vec(input logic [L-1:0] mask, input bit gap, input bit pulse, input int abort_at);
    int n, nb, xfers, lat, ecyc, guard;
    logic [W-1:0]    dense [L];
    logic [W-1:0]    q[$];
    logic [16*W-1:0] bundle, expb;

    n  = $countones(mask);
    nb = (n + 15) / 16;
    q  = g_words;
    for (int k = 0; k < L; k++)
      dense[k] = mask[k] ? q.pop_front() : '0;

    i_mask = mask;
    input_ready = 1'b1;
    tick();
    input_ready = 1'b0;
    lat = 1;
    check("enter_load", state, 2'b01);

    xfers = 0;
    guard = 0;
    while (state == 2'b01 && guard < 40) begin
      bus.i_valid = gap ? ((guard % 2) == 1) : 1'b1;
      for (int j = 0; j < 16; j++)
        bundle[j*W +: W] = (16*xfers + j < n) ? g_words[16*xfers + j] : (W'(20'hFACE0) | W'(j));
      bus.i_im = bundle;
      if (bus.o_accept && bus.i_valid) xfers++;
      tick();
      lat++;
      guard++;
    end
    bus.i_valid = 1'b1;
    check("transfers", xfers, nb);
    check("load_exit", state, 2'b11);

    ecyc = 0;
    while (state == 2'b11 && ecyc < 100) begin
      if (ecyc == 3) begin
        check("accept_in_expand", bus.o_accept, 1'b0);
        check("oim_in_expand", o_im, '0);
      end
      if (abort_at != 0 && ecyc == abort_at) begin
        #1 reset = 1'b0;
        #1;
        check("rst_state", state, 2'b00);
        check("rst_accept", bus.o_accept, 1'b0);
        check("rst_beat", o_beat, 1'b0);
        check("rst_mask", o_mask, '0);
        check("rst_oim", o_im, '0);
        tick();
        #1 reset = 1'b1;
        bus.i_valid = 1'b0;
        output_taken = 1'b0;
        input_ready = 1'b0;
        return;
      end
      input_ready  = pulse && (ecyc == 10);
      output_taken = (ecyc == 5);
      tick();
      lat++;
      ecyc++;
    end
    input_ready  = 1'b0;
    output_taken = 1'b0;
    bus.i_valid  = 1'b0;
    check("expand_len", ecyc, L);
    check("out_state", state, 2'b10);
    if (!gap) check("latency", lat, L + nb + 2);

    for (int b = 0; b < NB; b++) begin
      for (int j = 0; j < 16; j++)
        expb[j*W +: W] = dense[16*b + j];
      check("beat_idx", o_beat, b);
      check("beat_mask", o_mask, mask);
      check("beat_data", o_im, expb);
      tick();
      check("hold_state", state, 2'b10);
      check("hold_data", o_im, expb);
      output_taken = 1'b1;
      tick();
      output_taken = 1'b0;
    end
    check("done_state", state, 2'b00);
    check("done_beat", o_beat, 1'b0);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_im    = '0;
    repeat (2) tick();
    check("reset_state", state, 2'b00);
    check("reset_accept", bus.o_accept, 1'b0);
    check("reset_beat", o_beat, 1'b0);
    check("reset_mask", o_mask, '0);
    check("reset_oim", o_im, '0);
    reset = 1'b1;
    tick();

    g_words = '{W'(5), W'(-7)};
    run_vec(32'h0000_0003, 1'b0, 1'b0, 0);

    g_words.delete();
    for (int i = 1; i <= 32; i++) g_words.push_back(W'(i));
    run_vec(32'hFFFF_FFFF, 1'b0, 1'b0, 0);

    g_words.delete();
    run_vec(32'h0000_0000, 1'b0, 1'b0, 0);

    g_words = '{W'(9), W'(11)};
    run_vec(32'h8000_0001, 1'b0, 1'b0, 0);

    m = 32'hFFF0_FF0F;
    fill(m);
    run_vec(m, 1'b0, 1'b0, 0);
    run_vec(m, 1'b1, 1'b1, 0);

    m = $urandom;
    fill(m);
    run_vec(m, 1'b0, 1'b0, 12);
    check("post_abort_idle", state, 2'b00);
    m = 32'hF0F0_1234;
    fill(m);
    run_vec(m, 1'b0, 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      m = $urandom;
      fill(m);
      run_vec(m, bit'(i % 2), bit'(i % 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
